// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF butterfly stage: SR enable, butterfly select, sum/diff select, twiddles.
// Latency: first valid_o HALF+1 cycles after sample 0 with contiguous input; controls are combinational.
// Backpressure: ready_o low only in DRAIN past count 0; valid_i while ready_o=0 is dropped.
// Build option: define CTRL_TWROM_EN for the internal 32-point twiddle table; otherwise WN_r/WN_i stay 0.
module sdf_stage_ctrl #(
  parameter int N    = 16,
  parameter int TW_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            sr_en,
  output logic            bf_sel,
  output logic            valid_o,
  output logic            out_sel,
  output logic            frame_o,
  output logic [4:0]      tw_idx,
  output logic [TW_W-1:0] WN_r,
  output logic [TW_W-1:0] WN_i,
  output logic [2:0]      state
);

  localparam int HALF  = N / 2;
  localparam int CW    = $clog2(N);
  // log2(32/N): scales a stage-local index into 32-point twiddle units
  localparam int SHIFT = 5 - CW;

  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] CNT_HLAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    BFLY  = 3'd2,
    OVLP  = 3'd3,
    DRAIN = 3'd4
  } st_t;

  st_t           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    tw_d;

  assign state = st_q;

  // Next-state, sample counter and combinational datapath controls
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    ready_o = 1'b1;
    sr_en   = valid_i;
    bf_sel  = 1'b0;
    case (st_q)
      IDLE: begin
        if (valid_i) begin
          cnt_d = CNT_ONE;
          // with N=2 sample 0 alone is the whole first half
          st_d  = (HALF == 1) ? BFLY : FILL;
        end
      end
      FILL, OVLP: begin
        if (valid_i) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_HLAST) st_d = BFLY;
        end
      end
      BFLY: begin
        bf_sel = 1'b1;
        if (valid_i) begin
          if (cnt_q == CNT_LAST) begin
            st_d  = DRAIN;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      DRAIN: begin
        // pending diffs leave the SR regardless of input; only slot 0 may
        // take the first sample of the next frame
        sr_en   = 1'b1;
        ready_o = (cnt_q == '0);
        if ((cnt_q == '0) && valid_i) begin
          st_d  = (HALF == 1) ? BFLY : OVLP;
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_HLAST) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Twiddle index: diff outputs (OVLP/DRAIN) use n=count, sums use n=0
  always_comb begin
    tw_d = 5'd0;
    if ((st_q == OVLP) || (st_q == DRAIN)) tw_d = 5'(cnt_q) << SHIFT;
  end

  // State and counter registers; reset abandons any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // Output-side flags aligned to the one-cycle datapath register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      out_sel <= 1'b0;
      frame_o <= 1'b0;
      tw_idx  <= 5'd0;
    end else begin
      valid_o <= (((st_q == BFLY) || (st_q == OVLP)) && valid_i) || (st_q == DRAIN);
      out_sel <= (st_q != BFLY);
      frame_o <= (st_q == BFLY) && valid_i && (cnt_q == CNT_HALF);
      tw_idx  <= tw_d;
    end
  end

`ifdef CTRL_TWROM_EN
  // Q2.6 round(64*cos(2*pi*k/32)), k = 0..15
  function automatic int rom_re(input logic [3:0] k);
    int v;
    case (k)
      4'd0:  v = 64;   4'd1:  v = 63;   4'd2:  v = 59;   4'd3:  v = 53;
      4'd4:  v = 45;   4'd5:  v = 36;   4'd6:  v = 24;   4'd7:  v = 12;
      4'd8:  v = 0;    4'd9:  v = -12;  4'd10: v = -24;  4'd11: v = -36;
      4'd12: v = -45;  4'd13: v = -53;  4'd14: v = -59;  default: v = -63;
    endcase
    return v;
  endfunction

  // Q2.6 round(-64*sin(2*pi*k/32)), k = 0..15
  function automatic int rom_im(input logic [3:0] k);
    int v;
    case (k)
      4'd0:  v = 0;    4'd1:  v = -12;  4'd2:  v = -24;  4'd3:  v = -36;
      4'd4:  v = -45;  4'd5:  v = -53;  4'd6:  v = -59;  4'd7:  v = -63;
      4'd8:  v = -64;  4'd9:  v = -63;  4'd10: v = -59;  4'd11: v = -53;
      4'd12: v = -45;  4'd13: v = -36;  4'd14: v = -24;  default: v = -12;
    endcase
    return v;
  endfunction

  // Twiddle lookup registered alongside tw_idx (diff indices never exceed 15)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WN_r <= '0;
      WN_i <= '0;
    end else begin
      WN_r <= TW_W'(rom_re(tw_d[3:0]));
      WN_i <= TW_W'(rom_im(tw_d[3:0]));
    end
  end
`else
  // No local table: tw_idx addresses a shared ROM outside this block
  assign WN_r = '0;
  assign WN_i = '0;
`endif

endmodule
